// File: rtl/lcd_block_mover.sv
// ST7920 128x64 graphics-mode controller: initialises the panel, then redraws the
// full GDRAM frame showing one filled block that four debounced keys move around.
module lcd_block_mover #(
    parameter int CLK_DIV  = 2500,
    parameter int DEB_BITS = 20,
    parameter int BLK_W    = 2,
    parameter int BLK_H    = 16,
    parameter int STEP_X   = 1,
    parameter int STEP_Y   = 4,
    parameter int X_INIT   = 7,
    parameter int Y_INIT   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] data,
    output logic       busy
);
    localparam int P    = 2 * CLK_DIV;
    localparam int CW   = (P > 2) ? $clog2(P) : 1;
    localparam int XMAX = 16 - BLK_W;
    localparam int YMAX = 64 - BLK_H;

    typedef enum logic [3:0] {
        RST_WAIT, FN0, MODE, DISP, FN1, ROW_Y, ROW_X, DATA, IDLE
    } state_t;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    // key_n bit order is {up, down, left, right}
    logic [3:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic [1:0]          sync_reg;
            logic [DEB_BITS-1:0] deb_reg;
            logic                at_max_reg;
            logic                at_max;

            assign at_max = &deb_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_reg   <= 2'b11;
                    deb_reg    <= '0;
                    at_max_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[0], key_n[gi]};
                    if (sync_reg[1])
                        deb_reg <= '0;
                    else if (!at_max)
                        deb_reg <= deb_reg + 1'b1;
                    at_max_reg <= at_max;
                end
            end

            // Single event per press: rising edge of the saturated condition.
            assign press[gi] = at_max & ~at_max_reg;
        end
    endgenerate

    dir_t win_dir;

    always_comb begin
        win_dir = DIR_RIGHT;
        if (press[3])
            win_dir = DIR_UP;
        else if (press[2])
            win_dir = DIR_DOWN;
        else if (press[1])
            win_dir = DIR_LEFT;
    end

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [5:0]    r_reg, r_next;
    logic [3:0]    c_reg, c_next;
    logic [3:0]    x_reg, x_moved;
    logic [5:0]    y_reg, y_moved;
    logic          pend_reg;
    dir_t          pend_dir_reg;
    logic          apply;
    logic          in_blk;
    logic          step_end;
    logic          rs_reg, en_reg, busy_reg;
    logic [7:0]    data_reg, data_next;
    logic [7:0]    x_ext, y_ext, c_ext, r_ext;

    assign step_end = (cnt_reg == CW'(P - 1));
    assign x_ext    = {4'b0000, x_reg};
    assign y_ext    = {2'b00, y_reg};

    // Wrapping moves keep the whole block on screen instead of splitting it.
    always_comb begin
        x_moved = x_reg;
        y_moved = y_reg;
        case (pend_dir_reg)
            DIR_UP:
                y_moved = (y_ext < 8'(STEP_Y)) ? 6'(YMAX) : 6'(y_ext - 8'(STEP_Y));
            DIR_DOWN:
                y_moved = (y_ext + 8'(STEP_Y) > 8'(YMAX)) ? 6'd0 : 6'(y_ext + 8'(STEP_Y));
            DIR_LEFT:
                x_moved = (x_ext < 8'(STEP_X)) ? 4'(XMAX) : 4'(x_ext - 8'(STEP_X));
            default:
                x_moved = (x_ext + 8'(STEP_X) > 8'(XMAX)) ? 4'd0 : 4'(x_ext + 8'(STEP_X));
        endcase
    end

    // The apply action takes no step of its own: it happens on the boundary
    // into the first ROW_Y of a frame, so positions change only between frames.
    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        apply      = 1'b0;
        case (state_reg)
            RST_WAIT: state_next = FN0;
            FN0:      state_next = MODE;
            MODE:     state_next = DISP;
            DISP:     state_next = FN1;
            FN1: begin
                apply      = 1'b1;
                r_next     = '0;
                state_next = ROW_Y;
            end
            ROW_Y:    state_next = ROW_X;
            ROW_X: begin
                c_next     = '0;
                state_next = DATA;
            end
            DATA: begin
                if (c_reg == 4'd15) begin
                    if (r_reg == 6'd63) begin
                        state_next = IDLE;
                    end else begin
                        r_next     = r_reg + 6'd1;
                        state_next = ROW_Y;
                    end
                end else begin
                    c_next = c_reg + 4'd1;
                end
            end
            IDLE: begin
                if (pend_reg) begin
                    apply      = 1'b1;
                    r_next     = '0;
                    state_next = ROW_Y;
                end
            end
            default:  state_next = RST_WAIT;
        endcase

        c_ext  = {4'b0000, c_next};
        r_ext  = {2'b00, r_next};
        in_blk = (c_ext >= x_ext) && (c_ext < x_ext + 8'(BLK_W)) &&
                 (r_ext >= y_ext) && (r_ext < y_ext + 8'(BLK_H));

        case (state_next)
            FN0:     data_next = 8'h30;
            MODE:    data_next = 8'h06;
            DISP:    data_next = 8'h0C;
            FN1:     data_next = 8'h36;
            ROW_Y:   data_next = {3'b100, r_next[4:0]};
            ROW_X:   data_next = {4'b1000, r_next[5], 3'b000};
            DATA:    data_next = in_blk ? 8'hFF : 8'h00;
            default: data_next = data_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RST_WAIT;
            cnt_reg      <= '0;
            r_reg        <= '0;
            c_reg        <= '0;
            x_reg        <= 4'(X_INIT);
            y_reg        <= 6'(Y_INIT);
            pend_reg     <= 1'b0;
            pend_dir_reg <= DIR_UP;
            rs_reg       <= 1'b0;
            en_reg       <= 1'b0;
            data_reg     <= 8'h00;
            busy_reg     <= 1'b0;
        end else begin
            // A fresh event in the apply cycle survives for the next frame.
            if (step_end && apply)
                pend_reg <= 1'b0;
            if (|press) begin
                pend_reg     <= 1'b1;
                pend_dir_reg <= win_dir;
            end

            if (step_end) begin
                cnt_reg   <= '0;
                state_reg <= state_next;
                r_reg     <= r_next;
                c_reg     <= c_next;
                if (apply && pend_reg) begin
                    x_reg <= x_moved;
                    y_reg <= y_moved;
                end
                rs_reg   <= (state_next == DATA);
                data_reg <= data_next;
                busy_reg <= !(state_next inside {RST_WAIT, IDLE});
                en_reg   <= 1'b0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
                // Strobe only the second half so data settles before en falls.
                if (cnt_reg == CW'(CLK_DIV - 1) && !(state_reg inside {RST_WAIT, IDLE}))
                    en_reg <= 1'b1;
            end
        end
    end

    assign rs   = rs_reg;
    assign rw   = 1'b0;
    assign en   = en_reg;
    assign data = data_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_lcd_block_mover.sv
// Bench for lcd_block_mover: captures every LCD transfer on the falling strobe and
// compares whole frames against a block-position model driven by key presses.
module tb_lcd_block_mover;
    localparam int CLK_DIV  = 2;
    localparam int DEB_BITS = 3;
    localparam int BLK_W    = 2;
    localparam int BLK_H    = 16;
    localparam int STEP_X   = 1;
    localparam int STEP_Y   = 4;
    localparam int X_INIT   = 7;
    localparam int Y_INIT   = 24;
    localparam int P        = 2 * CLK_DIV;
    localparam int FRAME    = 64 * 18;
    localparam int XMAX     = 16 - BLK_W;
    localparam int YMAX     = 64 - BLK_H;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       rs, rw, en, busy;
    logic [7:0] data;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] xfer_q[$];
    logic [8:0] cap       = '0;
    logic       en_d      = 1'b0;
    int         en_w      = 0;
    int         width_err = 0;
    int         stab_err  = 0;

    int x_m, y_m, pend_dir_m;
    bit pend_m;

    lcd_block_mover #(
        .CLK_DIV(CLK_DIV), .DEB_BITS(DEB_BITS), .BLK_W(BLK_W), .BLK_H(BLK_H),
        .STEP_X(STEP_X), .STEP_Y(STEP_Y), .X_INIT(X_INIT), .Y_INIT(Y_INIT)
    ) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .rs(rs), .rw(rw),
        .en(en), .data(data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Transfer monitor: the panel latches {rs,data} when en falls.
    always @(negedge clk) begin
        if (en) begin
            if (en_d && {rs, data} !== cap) stab_err++;
            en_w++;
            cap = {rs, data};
        end else if (en_d) begin
            xfer_q.push_back(cap);
            if (en_w != CLK_DIV) width_err++;
            en_w = 0;
        end
        en_d = en;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        x_m = X_INIT; y_m = Y_INIT; pend_m = 0; pend_dir_m = 0;
    endfunction

    // held is active-high {up,down,left,right}; highest-priority key wins the slot.
    function automatic void model_press(logic [3:0] held);
        pend_m = 1;
        if (held[3])      pend_dir_m = 0;
        else if (held[2]) pend_dir_m = 1;
        else if (held[1]) pend_dir_m = 2;
        else              pend_dir_m = 3;
    endfunction

    function automatic void model_frame_start();
        if (pend_m) begin
            case (pend_dir_m)
                0:       y_m = (y_m < STEP_Y) ? YMAX : y_m - STEP_Y;
                1:       y_m = (y_m + STEP_Y > YMAX) ? 0 : y_m + STEP_Y;
                2:       x_m = (x_m < STEP_X) ? XMAX : x_m - STEP_X;
                default: x_m = (x_m + STEP_X > XMAX) ? 0 : x_m + STEP_X;
            endcase
        end
        pend_m = 0;
    endfunction

    function automatic logic [8:0] init_word(int i);
        case (i)
            0:       return 9'h030;
            1:       return 9'h006;
            2:       return 9'h00C;
            default: return 9'h036;
        endcase
    endfunction

    // Expected k-th transfer of a frame: two address commands then 16 pixel bytes per row.
    function automatic logic [8:0] expect_xfer(int k, int x, int y);
        int r, s, c;
        r = k / 18;
        s = k % 18;
        c = s - 2;
        if (s == 0) return {1'b0, 8'h80 + 8'(r % 32)};
        if (s == 1) return {1'b0, (r >= 32) ? 8'h88 : 8'h80};
        return {1'b1, (c >= x && c < x + BLK_W && r >= y && r < y + BLK_H) ? 8'hFF : 8'h00};
    endfunction

    function automatic logic [8:0] got_at(int idx);
        if (idx < xfer_q.size()) return xfer_q[idx];
        return 9'bx;
    endfunction

    function automatic int first_diff(int off, int x, int y);
        for (int k = 0; k < FRAME; k++)
            if (got_at(off + k) !== expect_xfer(k, x, y)) return k;
        return -1;
    endfunction

    function automatic int pix(int off, int r, int c);
        return off + r * 18 + 2 + c;
    endfunction

    task automatic press_keys(logic [3:0] mask, int hold);
        key_n = ~mask;
        repeat (hold) @(negedge clk);
        key_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_frame(output int bc, output bit to);
        int n;
        n = 0; bc = 0; to = 0;
        while (busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (busy !== 1'b1) begin to = 1; return; end
        while (busy === 1'b1 && bc < FRAME * P * 2) begin @(negedge clk); bc++; end
        if (busy === 1'b1) to = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int bc, d; bit to;
        rst = 1'b0; key_n = 4'hF;
        repeat (4) @(negedge clk);
        vectors++; if (rs !== 1'b0)      begin miscompares++; $display("FAIL reset_rs: got %b want 0", rs); end
        vectors++; if (en !== 1'b0)      begin miscompares++; $display("FAIL reset_en: got %b want 0", en); end
        vectors++; if (data !== 8'h00)   begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (rw !== 1'b0)      begin miscompares++; $display("FAIL reset_rw: got %b want 0", rw); end
        model_reset();
        xfer_q.delete();
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_wait_busy: got %b want 0", busy); end
        run_frame(bc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL init_timeout: busy did not complete"); end
        vectors++; if (bc != (4 + FRAME) * P) begin miscompares++; $display("FAIL busy_len: got %0d cycles want %0d", bc, (4 + FRAME) * P); end
        vectors++; if (xfer_q.size() != 4 + FRAME) begin miscompares++; $display("FAIL init_count: got %0d want %0d", xfer_q.size(), 4 + FRAME); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_at(i) !== init_word(i)) begin miscompares++; $display("FAIL init_cmd%0d: got %h want %h", i, got_at(i), init_word(i)); end
        end
        d = first_diff(4, x_m, y_m);
        vectors++; if (d != -1) begin miscompares++; $display("FAIL init_frame @%0d: got %h want %h", d, got_at(4 + d), expect_xfer(d, x_m, y_m)); end
        vectors++; if (got_at(pix(4, 24, 7)) !== 9'h1FF) begin miscompares++; $display("FAIL r24_b7: got %h want 1ff", got_at(pix(4, 24, 7))); end
        vectors++; if (got_at(pix(4, 24, 8)) !== 9'h1FF) begin miscompares++; $display("FAIL r24_b8: got %h want 1ff", got_at(pix(4, 24, 8))); end
        vectors++; if (got_at(pix(4, 24, 9)) !== 9'h100) begin miscompares++; $display("FAIL r24_b9: got %h want 100", got_at(pix(4, 24, 9))); end
        $display("reset frame: %0d transfers, busy %0d cycles", xfer_q.size(), bc);
    endtask

    task automatic test_right_hold();
        int bc, d, busy_seen; bit to;
        xfer_q.delete();
        key_n = 4'b1110;
        model_press(4'b0001); model_frame_start();
        run_frame(bc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL right_timeout: no redraw"); end
        vectors++; if (xfer_q.size() != FRAME) begin miscompares++; $display("FAIL right_count: got %0d want %0d", xfer_q.size(), FRAME); end
        d = first_diff(0, x_m, y_m);
        vectors++; if (d != -1) begin miscompares++; $display("FAIL right_frame @%0d: got %h want %h", d, got_at(d), expect_xfer(d, x_m, y_m)); end
        vectors++; if (got_at(pix(0, 24, 8)) !== 9'h1FF) begin miscompares++; $display("FAIL right_b8: got %h want 1ff", got_at(pix(0, 24, 8))); end
        vectors++; if (got_at(pix(0, 24, 9)) !== 9'h1FF) begin miscompares++; $display("FAIL right_b9: got %h want 1ff", got_at(pix(0, 24, 9))); end
        vectors++; if (got_at(pix(0, 24, 7)) !== 9'h100) begin miscompares++; $display("FAIL right_b7: got %h want 100", got_at(pix(0, 24, 7))); end
        xfer_q.delete();
        busy_seen = 0;
        repeat (200) begin @(negedge clk); if (busy === 1'b1) busy_seen++; end
        vectors++; if (busy_seen != 0) begin miscompares++; $display("FAIL hold_repeat_busy: got %0d busy cycles want 0", busy_seen); end
        vectors++; if (xfer_q.size() != 0) begin miscompares++; $display("FAIL hold_repeat_xfers: got %0d want 0", xfer_q.size()); end
        key_n = 4'hF;
        repeat (4) @(negedge clk);
        $display("right hold: x=%0d y=%0d", x_m, y_m);
    endtask

    task automatic test_up_wrap();
        int bc, d; bit to;
        for (int i = 0; i < 7; i++) begin
            xfer_q.delete();
            press_keys(4'b1000, 16);
            model_press(4'b1000); model_frame_start();
            run_frame(bc, to);
            vectors++; if (to) begin miscompares++; $display("FAIL up%0d_timeout: no redraw", i); end
            d = first_diff(0, x_m, y_m);
            vectors++; if (d != -1) begin miscompares++; $display("FAIL up%0d_frame @%0d: got %h want %h", i, d, got_at(d), expect_xfer(d, x_m, y_m)); end
            $display("up press %0d: x=%0d y=%0d", i, x_m, y_m);
        end
        vectors++; if (got_at(48 * 18) !== 9'h090)     begin miscompares++; $display("FAIL wrap_rowy: got %h want 090", got_at(48 * 18)); end
        vectors++; if (got_at(48 * 18 + 1) !== 9'h088) begin miscompares++; $display("FAIL wrap_rowx: got %h want 088", got_at(48 * 18 + 1)); end
        vectors++; if (got_at(pix(0, 48, 8)) !== 9'h1FF) begin miscompares++; $display("FAIL wrap_top: got %h want 1ff", got_at(pix(0, 48, 8))); end
        vectors++; if (got_at(pix(0, 47, 8)) !== 9'h100) begin miscompares++; $display("FAIL wrap_above: got %h want 100", got_at(pix(0, 47, 8))); end
    endtask

    task automatic test_priority();
        int bc, d; bit to;
        xfer_q.delete();
        press_keys(4'b1010, 16);
        model_press(4'b1010); model_frame_start();
        run_frame(bc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL prio_timeout: no redraw"); end
        d = first_diff(0, x_m, y_m);
        vectors++; if (d != -1) begin miscompares++; $display("FAIL prio_frame @%0d: got %h want %h", d, got_at(d), expect_xfer(d, x_m, y_m)); end
        vectors++; if (got_at(pix(0, 44, 7)) !== 9'h100) begin miscompares++; $display("FAIL prio_left_ignored: got %h want 100", got_at(pix(0, 44, 7))); end
        vectors++; if (got_at(pix(0, 44, 8)) !== 9'h1FF) begin miscompares++; $display("FAIL prio_up_applied: got %h want 1ff", got_at(pix(0, 44, 8))); end
        $display("up+left: x=%0d y=%0d", x_m, y_m);
    endtask

    task automatic test_back_to_back();
        int bc, d, busy_seen; bit to;
        xfer_q.delete();
        press_keys(4'b0001, 16);
        model_press(4'b0001); model_frame_start();
        repeat (100) @(negedge clk);
        press_keys(4'b0010, 16); model_press(4'b0010);
        press_keys(4'b0100, 16); model_press(4'b0100);
        run_frame(bc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL b2b_a_timeout: frame did not end"); end
        vectors++; if (xfer_q.size() != FRAME) begin miscompares++; $display("FAIL b2b_a_count: got %0d want %0d", xfer_q.size(), FRAME); end
        d = first_diff(0, x_m, y_m);
        vectors++; if (d != -1) begin miscompares++; $display("FAIL b2b_a_frame @%0d: got %h want %h", d, got_at(d), expect_xfer(d, x_m, y_m)); end
        $display("b2b frame A: x=%0d y=%0d", x_m, y_m);
        xfer_q.delete();
        model_frame_start();
        run_frame(bc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL b2b_b_timeout: queued move not drawn"); end
        vectors++; if (xfer_q.size() != FRAME) begin miscompares++; $display("FAIL b2b_b_count: got %0d want %0d", xfer_q.size(), FRAME); end
        d = first_diff(0, x_m, y_m);
        vectors++; if (d != -1) begin miscompares++; $display("FAIL b2b_b_frame @%0d: got %h want %h", d, got_at(d), expect_xfer(d, x_m, y_m)); end
        busy_seen = 0;
        repeat (100) begin @(negedge clk); if (busy === 1'b1) busy_seen++; end
        vectors++; if (busy_seen != 0) begin miscompares++; $display("FAIL b2b_extra_frame: got %0d busy cycles want 0", busy_seen); end
        $display("b2b frame B: x=%0d y=%0d", x_m, y_m);
    endtask

    task automatic test_random();
        int bc, d, hold; bit to;
        logic [3:0] mask;
        for (int i = 0; i < 2; i++) begin
            mask = 4'($urandom_range(1, 15));
            hold = $urandom_range(12, 30);
            xfer_q.delete();
            press_keys(mask, hold);
            model_press(mask); model_frame_start();
            run_frame(bc, to);
            vectors++; if (to) begin miscompares++; $display("FAIL rand%0d_timeout: no redraw", i); end
            d = first_diff(0, x_m, y_m);
            vectors++; if (d != -1) begin miscompares++; $display("FAIL rand%0d_frame @%0d: got %h want %h", i, d, got_at(d), expect_xfer(d, x_m, y_m)); end
            $display("random press mask=%b hold=%0d: x=%0d y=%0d", mask, hold, x_m, y_m);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bc, d, n, busy_seen; bit to;
        vectors++; if (stab_err != 0)  begin miscompares++; $display("FAIL data_stable: got %0d violations want 0", stab_err); end
        vectors++; if (width_err != 0) begin miscompares++; $display("FAIL en_width: got %0d bad pulses want 0", width_err); end
        press_keys(4'b0100, 16);
        model_press(4'b0100); model_frame_start();
        repeat (1500) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
        press_keys(4'b1000, 16);
        n = 0;
        while (en !== 1'b1 && n < 4 * P) begin @(negedge clk); n++; end
        #2 rst = 1'b0;
        #1;
        vectors++; if (en !== 1'b0)    begin miscompares++; $display("FAIL mid_rst_en: got %b want 0", en); end
        vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL mid_rst_data: got %h want 00", data); end
        vectors++; if (rs !== 1'b0)    begin miscompares++; $display("FAIL mid_rst_rs: got %b want 0", rs); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        #1;
        xfer_q.delete();
        stab_err = 0; width_err = 0;
        model_reset();
        rst = 1'b1;
        run_frame(bc, to);
        vectors++; if (to) begin miscompares++; $display("FAIL reinit_timeout: busy did not complete"); end
        vectors++; if (bc != (4 + FRAME) * P) begin miscompares++; $display("FAIL reinit_busy_len: got %0d want %0d", bc, (4 + FRAME) * P); end
        vectors++; if (xfer_q.size() != 4 + FRAME) begin miscompares++; $display("FAIL reinit_count: got %0d want %0d", xfer_q.size(), 4 + FRAME); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_at(i) !== init_word(i)) begin miscompares++; $display("FAIL reinit_cmd%0d: got %h want %h", i, got_at(i), init_word(i)); end
        end
        d = first_diff(4, x_m, y_m);
        vectors++; if (d != -1) begin miscompares++; $display("FAIL reinit_frame @%0d: got %h want %h", d, got_at(4 + d), expect_xfer(d, x_m, y_m)); end
        busy_seen = 0;
        repeat (100) begin @(negedge clk); if (busy === 1'b1) busy_seen++; end
        vectors++; if (busy_seen != 0) begin miscompares++; $display("FAIL reinit_pending_kept: got %0d busy cycles want 0", busy_seen); end
        vectors++; if (stab_err != 0)  begin miscompares++; $display("FAIL reinit_stable: got %0d violations want 0", stab_err); end
        vectors++; if (width_err != 0) begin miscompares++; $display("FAIL reinit_en_width: got %0d bad pulses want 0", width_err); end
        $display("mid-frame reset: re-init x=%0d y=%0d", x_m, y_m);
    endtask

    initial begin
        test_reset();
        test_right_hold();
        test_up_wrap();
        test_priority();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
